// File: rtl/sd_sim_pkg.sv
// Shared definitions for the simulation-side SD block responder.
package sd_sim_pkg;

   localparam int BLK_BYTES = 512;
   localparam int BLK_AW    = 9;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_WAIT = 2'd1,
      ST_XFER = 2'd2,
      ST_DONE = 2'd3
   } sd_state_t;

   typedef enum logic {
      DIR_RD = 1'b0,
      DIR_WR = 1'b1
   } sd_dir_t;

endpackage

// File: rtl/sd_img_responder.sv
// Responder end of the sd_rd/sd_wr/sd_ack block protocol for one drive slot.
// Moves 512-byte blocks between the core buffer port and a byte-wide
// synchronous image memory, and owns the mount state of the slot.
module sd_img_responder
   import sd_sim_pkg::*;
#(
   parameter int IMG_AW    = 25,
   parameter int ACK_DELAY = 4,
   parameter int BYTE_GAP  = 0
) (
   input  logic              clk_sys,
   input  logic              reset,
   input  logic [31:0]       sd_lba,
   input  logic              sd_rd,
   input  logic              sd_wr,
   output logic              sd_ack,
   output logic [8:0]        sd_buff_addr,
   output logic [7:0]        sd_buff_dout,
   output logic              sd_buff_wr,
   input  logic [7:0]        sd_buff_din,
   input  logic              mount_req,
   input  logic [63:0]       mount_size,
   input  logic              mount_readonly,
   output logic              img_mounted,
   output logic [63:0]       img_size,
   output logic              img_readonly,
   output logic [IMG_AW-1:0] img_addr,
   output logic              img_rd,
   input  logic [7:0]        img_rdata,
   output logic              img_wr,
   output logic [7:0]        img_wdata,
   output logic              busy
);

   sd_state_t   state_reg;
   sd_dir_t     dir_reg;
   logic [31:0] lba_reg;
   logic [15:0] wait_cnt_reg;
   logic [15:0] gap_cnt_reg;
   logic [9:0]  issue_cnt_reg;   // next byte index to issue; bit 9 = block finished
   logic        s0_valid_reg;    // byte issued this cycle (memory read / buffer address)
   logic [8:0]  s0_idx_reg;
   logic        s1_valid_reg;    // byte completing this cycle (strobe / memory write)
   logic [8:0]  s1_idx_reg;
   logic        ack_reg;

   logic        pend_reg;
   logic [63:0] pend_size_reg;
   logic        pend_ro_reg;
   logic        mounted_reg;
   logic [63:0] size_reg;
   logic        ro_reg;

   logic        out_of_range;
   logic [40:0] blk_base;
   logic [8:0]  mem_idx;
   logic        is_rd;

   // Block start offset compared against the image size; also reject LBAs the
   // image address bus cannot represent.
   assign blk_base     = {lba_reg, 9'd0};
   assign out_of_range = ({23'd0, blk_base} >= size_reg) ||
                         ((lba_reg >> (IMG_AW - BLK_AW)) != 32'd0);

   assign is_rd   = (dir_reg == DIR_RD);
   // Reads address memory at issue; writes address memory one cycle later,
   // when the core's registered buffer data arrives.
   assign mem_idx = is_rd ? s0_idx_reg : s1_idx_reg;

   assign sd_ack       = ack_reg;
   assign sd_buff_addr = is_rd ? s1_idx_reg : s0_idx_reg;
   assign sd_buff_wr   = s1_valid_reg && is_rd;
   assign sd_buff_dout = (sd_buff_wr && !out_of_range) ? img_rdata : 8'h00;
   assign img_addr     = {lba_reg[IMG_AW-BLK_AW-1:0], mem_idx};
   assign img_rd       = s0_valid_reg && is_rd && !out_of_range;
   assign img_wr       = s1_valid_reg && !is_rd && !out_of_range && !ro_reg;
   assign img_wdata    = img_wr ? sd_buff_din : 8'h00;
   assign busy         = (state_reg != ST_IDLE);
   assign img_mounted  = mounted_reg;
   assign img_size     = size_reg;
   assign img_readonly = ro_reg;

   // Request FSM and the two-stage byte pipeline.
   always_ff @(posedge clk_sys) begin
      if (reset) begin
         state_reg     <= ST_IDLE;
         dir_reg       <= DIR_RD;
         lba_reg       <= 32'd0;
         wait_cnt_reg  <= 16'd0;
         gap_cnt_reg   <= 16'd0;
         issue_cnt_reg <= 10'd0;
         s0_valid_reg  <= 1'b0;
         s0_idx_reg    <= 9'd0;
         s1_valid_reg  <= 1'b0;
         s1_idx_reg    <= 9'd0;
         ack_reg       <= 1'b0;
      end else begin
         s1_valid_reg <= s0_valid_reg;
         s1_idx_reg   <= s0_idx_reg;
         s0_valid_reg <= 1'b0;
         case (state_reg)
            ST_IDLE: begin
               if (sd_rd || sd_wr) begin
                  lba_reg      <= sd_lba;
                  dir_reg      <= sd_rd ? DIR_RD : DIR_WR;
                  wait_cnt_reg <= 16'd0;
                  s0_idx_reg   <= 9'd0;
                  state_reg    <= ST_WAIT;
               end
            end
            ST_WAIT: begin
               if (wait_cnt_reg == 16'(ACK_DELAY - 1)) begin
                  ack_reg       <= 1'b1;
                  s0_valid_reg  <= 1'b1;
                  s0_idx_reg    <= 9'd0;
                  issue_cnt_reg <= 10'd1;
                  gap_cnt_reg   <= 16'(BYTE_GAP);
                  state_reg     <= ST_XFER;
               end else begin
                  wait_cnt_reg <= wait_cnt_reg + 16'd1;
               end
            end
            ST_XFER: begin
               if (!issue_cnt_reg[9]) begin
                  if (gap_cnt_reg == 16'd0) begin
                     s0_valid_reg  <= 1'b1;
                     s0_idx_reg    <= issue_cnt_reg[8:0];
                     issue_cnt_reg <= issue_cnt_reg + 10'd1;
                     gap_cnt_reg   <= 16'(BYTE_GAP);
                  end else begin
                     gap_cnt_reg <= gap_cnt_reg - 16'd1;
                  end
               end
               if (s1_valid_reg && (s1_idx_reg == 9'd511)) begin
                  ack_reg   <= 1'b0;
                  state_reg <= ST_DONE;
               end
            end
            default: begin
               state_reg <= ST_IDLE;
            end
         endcase
      end
   end

   // Mount handling; a mount arriving mid-transfer is held until IDLE.
   always_ff @(posedge clk_sys) begin
      if (reset) begin
         pend_reg      <= 1'b0;
         pend_size_reg <= 64'd0;
         pend_ro_reg   <= 1'b0;
         mounted_reg   <= 1'b0;
         size_reg      <= 64'd0;
         ro_reg        <= 1'b0;
      end else begin
         mounted_reg <= 1'b0;
         if (mount_req && state_reg == ST_IDLE) begin
            size_reg    <= mount_size;
            ro_reg      <= mount_readonly;
            mounted_reg <= 1'b1;
            pend_reg    <= 1'b0;
         end else if (mount_req) begin
            pend_reg      <= 1'b1;
            pend_size_reg <= mount_size;
            pend_ro_reg   <= mount_readonly;
         end else if (pend_reg && state_reg == ST_IDLE) begin
            size_reg    <= pend_size_reg;
            ro_reg      <= pend_ro_reg;
            mounted_reg <= 1'b1;
            pend_reg    <= 1'b0;
         end
      end
   end

endmodule

// File: tb/tb_sd_img_responder.sv
// Bench for sd_img_responder: behavioural image RAM and core buffer, with an
// expected-image array and block-level rules as the reference.
module tb_sd_img_responder;

   localparam int IMG_AW    = 25;
   localparam int ACK_DELAY = 4;
   localparam int BYTE_GAP  = 0;
   localparam int MEM_BYTES = 1 << 20;

   logic              clk_sys = 1'b0;
   logic              reset = 1'b1;
   logic [31:0]       sd_lba = 32'd0;
   logic              sd_rd = 1'b0;
   logic              sd_wr = 1'b0;
   logic              sd_ack;
   logic [8:0]        sd_buff_addr;
   logic [7:0]        sd_buff_dout;
   logic              sd_buff_wr;
   logic [7:0]        sd_buff_din = 8'd0;
   logic              mount_req = 1'b0;
   logic [63:0]       mount_size = 64'd0;
   logic              mount_readonly = 1'b0;
   logic              img_mounted;
   logic [63:0]       img_size;
   logic              img_readonly;
   logic [IMG_AW-1:0] img_addr;
   logic              img_rd;
   logic [7:0]        img_rdata = 8'd0;
   logic              img_wr;
   logic [7:0]        img_wdata;
   logic              busy;

   sd_img_responder #(.IMG_AW(IMG_AW), .ACK_DELAY(ACK_DELAY), .BYTE_GAP(BYTE_GAP)) dut (
      .clk_sys(clk_sys), .reset(reset), .sd_lba(sd_lba), .sd_rd(sd_rd), .sd_wr(sd_wr),
      .sd_ack(sd_ack), .sd_buff_addr(sd_buff_addr), .sd_buff_dout(sd_buff_dout),
      .sd_buff_wr(sd_buff_wr), .sd_buff_din(sd_buff_din), .mount_req(mount_req),
      .mount_size(mount_size), .mount_readonly(mount_readonly), .img_mounted(img_mounted),
      .img_size(img_size), .img_readonly(img_readonly), .img_addr(img_addr),
      .img_rd(img_rd), .img_rdata(img_rdata), .img_wr(img_wr), .img_wdata(img_wdata),
      .busy(busy)
   );

   always #5 clk_sys = ~clk_sys;

   logic [7:0] ram_mem [0:MEM_BYTES-1];
   logic [7:0] ref_mem [0:MEM_BYTES-1];
   logic [7:0] core_buf [0:511];
   int         hi_acc = 0;

   // Image memory with registered read, plus the core's registered buffer read.
   always @(posedge clk_sys) begin
      if (img_wr) ram_mem[img_addr[19:0]] <= img_wdata;
      if (img_rd) img_rdata <= ram_mem[img_addr[19:0]];
      if ((img_rd || img_wr) && img_addr[IMG_AW-1:20] != '0) hi_acc <= hi_acc + 1;
      sd_buff_din <= core_buf[sd_buff_addr];
   end

   int n_checks = 0;
   int n_fail   = 0;

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   // Reference mount state
   logic [63:0] cur_size = 64'd0;
   logic        cur_ro   = 1'b0;

   function automatic bit in_range(input logic [31:0] lba);
      return ((64'(lba) * 64'd512) < cur_size) && (lba < 32'(1 << (IMG_AW - 9)));
   endfunction

   // Per-transaction observations
   logic [8:0] q_addr[$];
   logic [7:0] q_data[$];
   int rd_cnt, wr_cnt, viol, tick, last_evt;

   task automatic sample();
      tick++;
      if (sd_buff_wr) begin
         q_addr.push_back(sd_buff_addr);
         q_data.push_back(sd_buff_dout);
         last_evt = tick;
         if (!sd_ack) viol++;
      end
      if (img_rd) rd_cnt++;
      if (img_wr) begin
         wr_cnt++;
         last_evt = tick;
      end
   endtask

   task automatic do_mount(input logic [63:0] size, input logic ro);
      int pulses;
      @(negedge clk_sys);
      mount_size = size; mount_readonly = ro; mount_req = 1'b1;
      @(negedge clk_sys);
      mount_req = 1'b0;
      check("mnt_first", {63'd0, img_mounted}, 64'd1);
      pulses = int'(img_mounted);
      for (int i = 0; i < 3; i++) begin
         @(negedge clk_sys);
         pulses += int'(img_mounted);
      end
      cur_size = size; cur_ro = ro;
      check("mnt_pulses", 64'(pulses), 64'd1);
      check("mnt_size", img_size, size);
      check("mnt_ro", {63'd0, img_readonly}, {63'd0, ro});
      $display("mount size=0x%0h ro=%0d", size, ro);
   endtask

   // Issue one request; abort_at >= 0 pulses reset once that byte has strobed.
   task automatic run_req(input logic rd, input logic wr, input logic [31:0] lba, input int abort_at);
      int n, len;
      q_addr.delete(); q_data.delete();
      rd_cnt = 0; wr_cnt = 0; viol = 0; last_evt = -1;
      @(negedge clk_sys);
      sd_lba = lba; sd_rd = rd; sd_wr = wr;
      n = 0;
      do begin
         @(negedge clk_sys); sample(); n++;
      end while (!sd_ack && n < 100);
      check("ack_lat", 64'(n), 64'(ACK_DELAY + 1));
      sd_rd = 1'b0; sd_wr = 1'b0;
      len = 1;
      while (sd_ack && len < 20000) begin
         if (abort_at >= 0 && q_addr.size() == abort_at + 1) break;
         @(negedge clk_sys); sample();
         if (sd_ack) len++;
      end
      if (abort_at >= 0) begin
         reset = 1'b1;
         @(negedge clk_sys);
         check("rst_ack", {63'd0, sd_ack}, 64'd0);
         check("rst_bwr", {63'd0, sd_buff_wr}, 64'd0);
         check("rst_busy", {63'd0, busy}, 64'd0);
         reset = 1'b0;
         cur_size = 64'd0; cur_ro = 1'b0;
         $display("xfer abort lba=%0d strobes=%0d", lba, q_addr.size());
      end else begin
         check("ack_len", 64'(len), 64'(511 * (1 + BYTE_GAP) + 2));
         if (last_evt >= 0) check("ack_fall", 64'(tick - last_evt), 64'd1);
         @(negedge clk_sys);
         check("idle_busy", {63'd0, busy}, 64'd0);
         $display("xfer %s lba=%0d strobes=%0d img_rd=%0d img_wr=%0d ack_len=%0d",
                  rd ? "rd" : "wr", lba, q_addr.size(), rd_cnt, wr_cnt, len);
      end
      check("proto", 64'(viol), 64'd0);
   endtask

   task automatic do_read(input logic [31:0] lba);
      bit ok = in_range(lba);
      run_req(1'b1, 1'b0, lba, -1);
      check("rd_strobes", 64'(q_addr.size()), 64'd512);
      check("rd_memrd", 64'(rd_cnt), ok ? 64'd512 : 64'd0);
      for (int i = 0; i < q_addr.size(); i++) begin
         check("rd_addr", {55'd0, q_addr[i]}, 64'(i));
         check("rd_data", {56'd0, q_data[i]}, ok ? {56'd0, ref_mem[lba * 512 + i]} : 64'd0);
      end
   endtask

   task automatic do_write(input logic [31:0] lba);
      bit ok = in_range(lba) && !cur_ro;
      int base = int'(lba[10:0]) * 512;
      run_req(1'b0, 1'b1, lba, -1);
      check("wr_strobes", 64'(q_addr.size()), 64'd0);
      check("wr_memwr", 64'(wr_cnt), ok ? 64'd512 : 64'd0);
      if (ok) for (int i = 0; i < 512; i++) ref_mem[lba * 512 + i] = core_buf[i];
      if (lba < 2048) begin
         for (int i = -1; i <= 512; i++) begin
            if (base + i >= 0 && base + i < MEM_BYTES)
               check("wr_img", {56'd0, ram_mem[base + i]}, {56'd0, ref_mem[base + i]});
         end
      end
   endtask

   initial begin
      logic [31:0] lba, lba_b;
      logic [63:0] sz;
      for (int i = 0; i < MEM_BYTES; i++) begin
         ram_mem[i] = 8'($urandom);
         ref_mem[i] = ram_mem[i];
      end
      for (int i = 0; i < 512; i++) core_buf[i] = 8'd0;
      repeat (3) @(negedge clk_sys);
      reset = 1'b0;
      check("rst_ack0", {63'd0, sd_ack}, 64'd0);
      check("rst_busy0", {63'd0, busy}, 64'd0);
      check("rst_size0", img_size, 64'd0);
      check("rst_mnt0", {62'd0, img_mounted, img_readonly}, 64'd0);
      check("rst_strb0", {61'd0, sd_buff_wr, img_rd, img_wr}, 64'd0);

      // Unmounted: acked, zeros, nothing written
      do_read(32'd0);
      for (int i = 0; i < 512; i++) core_buf[i] = 8'($urandom);
      do_write(32'd1);

      do_mount(64'h10_0000, 1'b0);
      for (int i = 0; i < 512; i++) begin
         ram_mem[3 * 512 + i] = 8'(i) ^ 8'h5A;
         ref_mem[3 * 512 + i] = 8'(i) ^ 8'h5A;
      end
      do_read(32'd3);
      for (int i = 0; i < 512; i++) core_buf[i] = 8'hA5;
      do_write(32'd7);
      check("blk7_first", {56'd0, ram_mem[32'hE00]}, 64'hA5);
      check("blk7_last", {56'd0, ram_mem[32'hFFF]}, 64'hA5);

      do_mount(64'h10_0000, 1'b1);
      for (int i = 0; i < 512; i++) core_buf[i] = 8'h00;
      do_write(32'd7);
      check("ro_keep", {56'd0, ram_mem[32'hE80]}, 64'hA5);
      do_read(32'd4096);

      // Randomised phase with boundary LBAs around the mounted size
      for (int r = 0; r < 10; r++) begin
         if (r % 3 == 0) begin
            sz = 64'($urandom_range(1, 2047)) * 64'd512;
            if ($urandom_range(0, 1) == 1) sz = sz - 64'($urandom_range(1, 511));
            do_mount(sz, ($urandom_range(0, 3) == 0));
         end
         lba_b = 32'((cur_size + 64'd511) >> 9);
         case ($urandom_range(0, 2))
            0: lba = 32'($urandom_range(0, 2047));
            1: lba = lba_b - 32'd1;
            default: lba = lba_b;
         endcase
         if ($urandom_range(0, 1) == 1) begin
            do_read(lba);
         end else begin
            for (int i = 0; i < 512; i++) core_buf[i] = 8'($urandom);
            do_write(lba);
         end
      end

      // Both levels high -> read; reset at byte 100; then a clean read
      do_mount(64'h10_0000, 1'b0);
      run_req(1'b1, 1'b1, 32'd3, 100);
      check("both_strobes", 64'(q_addr.size()), 64'd101);
      for (int i = 0; i < q_addr.size(); i++) begin
         check("both_addr", {55'd0, q_addr[i]}, 64'(i));
         check("both_data", {56'd0, q_data[i]}, {56'd0, ref_mem[3 * 512 + i]});
      end
      check("both_nowr", 64'(wr_cnt), 64'd0);
      check("post_rst_size", img_size, 64'd0);
      do_read(32'd3);

      check("hi_addr", 64'(hi_acc), 64'd0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/sd_img_responder.md
Name: sd_img_responder

Overview:
- Simulation-side SD/image host for one drive slot; the responder end of the sd_rd/sd_wr/sd_ack/sd_buff_* block protocol used by the HDD request logic.
- Serves 512-byte block reads and writes against a byte-wide synchronous image memory, and generates the mount events (img_mounted pulse, size, readonly).
- Sits between the emu-level sd_* ports of one slot and a behavioural image RAM, so the full HDD path can be exercised in the simulator without host software.

Parameters:
- IMG_AW, 25, image memory byte-address width (32 MiB max image).
- ACK_DELAY, 4, idle cycles from request detect to sd_ack rise (minimum 1).
- BYTE_GAP, 0, idle cycles inserted between consecutive byte transfers.

Ports:
- clk_sys  in  1  system clock.
- reset  in  1  synchronous, active-high reset.
- sd_lba  in  32  block address, sampled at request detect.
- sd_rd  in  1  read request from core (level).
- sd_wr  in  1  write request from core (level).
- sd_ack  out  1  transfer-in-progress acknowledge.
- sd_buff_addr  out  9  byte index within block.
- sd_buff_dout  out  8  read data to core.
- sd_buff_wr  out  1  read-data strobe, one cycle per byte.
- sd_buff_din  in  8  write data from core, valid 1 cycle after sd_buff_addr.
- mount_req  in  1  testbench mount command (pulse).
- mount_size  in  64  image size in bytes for mount_req.
- mount_readonly  in  1  write-protect for mount_req.
- img_mounted  out  1  one-cycle mount event pulse.
- img_size  out  64  current image size in bytes.
- img_readonly  out  1  current write-protect.
- img_addr  out  IMG_AW  image memory byte address.
- img_rd  out  1  image memory read enable; data valid next cycle.
- img_rdata  in  8  image memory read data.
- img_wr  out  1  image memory write enable.
- img_wdata  out  8  image memory write data.
- busy  out  1  high in any state other than IDLE.

Behaviour:
- Reset: all outputs 0. img_size 0; state IDLE. Reset mid-transfer drops sd_ack and sd_buff_wr on the next edge; a partial write is not rolled back.
- Mount: mount_req registers mount_size and mount_readonly. img_mounted pulses high in the cycle after mount_req. Mount during a transfer is deferred until IDLE.
- States: IDLE -> WAIT -> XFER -> DONE -> IDLE.
- IDLE: when sd_rd or sd_wr is high, latch sd_lba and the direction (read wins if both are high), then go to WAIT.
- WAIT: count ACK_DELAY cycles, then assert sd_ack and enter XFER with byte index 0. Request levels are ignored from ack rise until DONE; the core drops them on ack rise.
- Byte address: img_addr = {lba, idx[8:0]} truncated to IMG_AW. Out of range when lba*512 >= img_size, or lba >= 2^(IMG_AW-9).
- XFER read:
  - Cycle t: img_rd=1 at byte k.
  - Cycle t+1: sd_buff_addr=k, sd_buff_dout=img_rdata (0x00 if out of range, and img_rd is suppressed), sd_buff_wr=1.
  - One byte per 1+BYTE_GAP cycles, pipelined. Last strobe is at k=511.
- XFER write:
  - Cycle t: sd_buff_addr=k.
  - Cycle t+1: capture sd_buff_din; img_wr=1, img_wdata=captured byte, img_addr for byte k.
  - img_wr is suppressed when img_readonly or out of range, but the byte still counts.
  - Same 1+BYTE_GAP pacing.
- DONE: entered the cycle after the final byte's strobe or write. sd_ack falls on DONE entry. The next cycle is IDLE, so sd_ack is low for at least 1 cycle before the next ack rise.
- Protocol rule: sd_buff_wr is only ever high while sd_ack is high. sd_buff_addr is strictly increasing 0..511 with no skips.
- Unmounted (img_size 0): every request is acked; reads return zeros, writes are discarded.
- Byte counter: 10-bit. The terminal condition is idx == 511 after issue; no wrap into a second block.

Decomposition:
- Shared package sd_sim_pkg: BLK_BYTES=512, BLK_AW=9, the state enum (IDLE/WAIT/XFER/DONE), and the direction type.
- No sub-module. Mount logic is a small always block inside this module; the image RAM stays external (the existing dpram).

Test Plan:
- Mount 1 MiB, not readonly -> img_mounted high exactly 1 cycle, img_size=0x100000, img_readonly=0.
- Preload LBA 3 with byte=idx^0x5A, pulse sd_rd with sd_lba=3 -> sd_ack rises 4+1 cycles after request; 512 strobes with addr 0..511 and data idx^0x5A; ack falls 1 cycle after strobe 511.
- Write LBA 7 from a core buffer filled with 0xA5 (sd_buff_din registered) -> image bytes 0xE00..0xFFF all 0xA5; bytes 0xDFF and 0x1000 unchanged.
- Remount readonly, then write LBA 7 with 0x00 -> full ack handshake, img_wr never asserted, image still 0xA5.
- Read at LBA 4096 on a 1 MiB image -> 512 strobes with data 0x00, img_rd never asserted.
- With sd_rd and sd_wr both high -> read performed; assert reset at byte 100 -> sd_ack=0 and sd_buff_wr=0 next cycle, busy=0; a new sd_rd is then served normally from byte 0.
